// File: rtl/fasrip_seq.sv
// fasrip_seq: multi-cycle wide add/subtract sequencer.
//
// A single 4-bit ripple add/sub slice (fasrip) is time-multiplexed over
// NIBBLES operand nibbles, LSB first. The inter-nibble carry is held in a
// register. The partial result is assembled in an accumulator. When the last
// nibble completes, the result, final carry and signed overflow are published
// on registered outputs. Valid/ready handshakes are used on both the operand
// side and the result side.
//
// Optional build macro: FASRIP_SEQ_BACK2BACK_EN
//   When defined, a result handoff and a new operand accept can happen on the
//   same edge, so the sequencer goes DONE->RUN without an idle bubble.
//   When undefined, DONE always returns through IDLE.
//
// Timing: out_valid rises exactly NIBBLES cycles after the accept edge.
module fasrip_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The 4-bit ripple add/sub slice. When s_op is 1, b is inverted and the
    // caller supplies cin=1, so the slice computes a - b. The result is
    // returned as {cout, s[3:0]}.
    function automatic logic [4:0] fasrip_slice(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin,
        input logic       s_op
    );
        logic       c;
        logic       bx;
        logic [3:0] s;
        c = cin;
        s = 4'h0;
        for (int i = 0; i < 4; i++) begin
            bx   = b[i] ^ s_op;
            s[i] = a[i] ^ bx ^ c;
            c    = (a[i] & bx) | (a[i] & c) | (bx & c);
        end
        return {c, s};
    endfunction

    // Two's-complement overflow. The effective B sign is b_msb ^ op.
    // Overflow occurs when A and the effective B have the same sign, and the
    // result sign differs from A.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic op,
        input logic s_msb
    );
        return (a_msb ~^ (b_msb ^ op)) & (s_msb ^ a_msb);
    endfunction

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             op_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W-1:0]     acc_r;
    logic [W-1:0]     out_sum_r;
    logic             out_cout_r;
    logic             out_ovf_r;
    logic             out_valid_r;

    logic [CNT_W+1:0] base_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [4:0]       slice_s;
    logic [W-1:0]     acc_next_s;
    logic             last_s;
    logic             in_ready_s;

    // Nibble selection and slice evaluation for the current count.
    always_comb begin
        base_s  = {cnt_r, 2'b00};
        a_nib_s = a_r[base_s +: 4];
        b_nib_s = b_r[base_s +: 4];
        slice_s = fasrip_slice(a_nib_s, b_nib_s, carry_r, op_r);
        last_s  = (cnt_r == LAST_CNT);
    end

    // Merge the freshly computed sum nibble into the accumulator image.
    always_comb begin
        acc_next_s               = acc_r;
        acc_next_s[base_s +: 4]  = slice_s[3:0];
    end

    // Operand-side readiness. This signal decodes state only, apart from
    // the reset gate and, when back-to-back is enabled, the same-edge
    // result handoff.
    always_comb begin
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
`ifdef FASRIP_SEQ_BACK2BACK_EN
            in_ready_s = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
`else
            in_ready_s = (state_r == ST_IDLE);
`endif
        end
    end

    // Sequencer state, operand latches, carry chain and published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            carry_r     <= 1'b0;
            op_r        <= 1'b0;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            acc_r       <= {W{1'b0}};
            out_sum_r   <= {W{1'b0}};
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        op_r    <= in_op;
                        carry_r <= in_op;
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_next_s;
                    carry_r <= slice_s[4];
                    if (last_s) begin
                        cnt_r       <= CNT_ZERO;
                        state_r     <= ST_DONE;
                        out_sum_r   <= acc_next_s;
                        out_cout_r  <= slice_s[4];
                        out_ovf_r   <= signed_ovf(a_r[W-1], b_r[W-1], op_r, slice_s[3]);
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
`ifdef FASRIP_SEQ_BACK2BACK_EN
                        if (in_valid) begin
                            a_r     <= in_a;
                            b_r     <= in_b;
                            op_r    <= in_op;
                            carry_r <= in_op;
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
`else
                        state_r <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= CNT_ZERO;
                    carry_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = (state_r != ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_cout  = out_cout_r;
    assign out_ovf   = out_ovf_r;

endmodule
